mole_field_ctrl: RTL and testbench

Game-logic stage that drives the mole/score renderer. It holds one pop-up state machine per hole (8 holes) and randomly spawns moles on a 40 Hz tick. It credits player whacks and packs each hole's rise height into the 40-bit mole-position bus, with 4-digit BCD hit and spawn counters. All outputs are registered and feed the renderer's molePositions, score and total inputs directly.

---
 rtl/mole_field_if.sv | 21 ++
 rtl/mole_field_ctrl.sv | 156 +++++++++++++++
 tb/tb_mole_field_ctrl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mole_field_if.sv
// Renderer-facing bundle of mole_field_ctrl: tick/enable/button inputs and the
// registered position, score and total buses.
interface mole_field_if;
   logic        tick_40;
   logic        game_en;
   logic [7:0]  whack;
   logic [39:0] mole_positions;
   logic [15:0] score;
   logic [15:0] total;
   logic        busy;

   modport master (
      output tick_40, game_en, whack,
      input  mole_positions, score, total, busy
   );

   modport slave (
      input  tick_40, game_en, whack,
      output mole_positions, score, total, busy
   );
endinterface

// File: rtl/mole_field_ctrl.sv
// Whack-a-mole game logic: eight pop-up hole FSMs, LFSR-driven spawning,
// synchronised whack crediting and saturating 4-digit BCD hit/spawn counters.
module mole_field_ctrl #(
   parameter logic [4:0]  MAX_SHIFT   = 5'd19,
   parameter logic [7:0]  UP_TICKS    = 8'd40,
   parameter logic [7:0]  SPAWN_TICKS = 8'd30,
   parameter logic [4:0]  HIT_MIN     = 5'd4,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input  logic         CLOCK_50,
   input  logic         resetn,
   mole_field_if.slave  mf
);

   localparam int unsigned N_HOLES = 8;
   localparam int unsigned HOLE_W  = 3;
   localparam int unsigned HGT_W   = 5;
   localparam int unsigned HOLD_W  = 8;
   localparam int unsigned BCD_W   = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RISING  = 2'd1,
      UP      = 2'd2,
      FALLING = 2'd3
   } hole_state_e;

   hole_state_e [N_HOLES-1:0]            state_q, state_d;
   logic        [N_HOLES-1:0][HGT_W-1:0]  height_q, height_d;
   logic        [N_HOLES-1:0][HOLD_W-1:0] hold_q, hold_d;
   logic                                  busy_q, busy_c;
   logic        [BCD_W-1:0]               score_q, total_q;
   logic        [HOLD_W-1:0]              spawn_cnt_q;
   logic        [15:0]                    lfsr_q;
   logic        [N_HOLES-1:0]             whack_s1_q, whack_s2_q, whack_prev_q;

   logic               step;
   logic               spawn_go;
   logic               spawn_ok;
   logic [HOLE_W-1:0]  spawn_hole;
   logic [N_HOLES-1:0] whack_edge;
   logic [N_HOLES-1:0] hit_ok;
   logic [N_HOLES-1:0] hit_sel;

   // Saturating BCD increment; 9999 is sticky.
   function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] v);
      logic [BCD_W-1:0] r;
      logic             carry;
      r     = v;
      carry = 1'b1;
      if (v != 16'h9999) begin
         for (int d = 0; d < 4; d++) begin
            if (carry) begin
               if (r[4*d +: 4] == 4'd9) begin
                  r[4*d +: 4] = 4'd0;
               end else begin
                  r[4*d +: 4] = r[4*d +: 4] + 4'd1;
                  carry       = 1'b0;
               end
            end
         end
      end
      return r;
   endfunction

   assign step       = mf.tick_40 & mf.game_en;
   assign spawn_go   = step && (spawn_cnt_q == '0);
   assign spawn_hole = lfsr_q[HOLE_W-1:0];
   assign spawn_ok   = spawn_go && (state_q[spawn_hole] == IDLE);
   assign whack_edge = whack_s2_q & ~whack_prev_q;

   always_comb begin
      hit_ok = '0;
      for (int i = 0; i < N_HOLES; i++) begin
         hit_ok[i] = whack_edge[i] & mf.game_en & (state_q[i] != IDLE) &
                     (height_q[i] >= HIT_MIN);
      end
   end

   // Lowest-index valid hit wins; the remaining edges are dropped.
   assign hit_sel = hit_ok & (~hit_ok + N_HOLES'(1));

   // Per-hole next state; a hit beats both spawn and tick movement.
   always_comb begin
      state_d  = state_q;
      height_d = height_q;
      hold_d   = hold_q;
      busy_c   = 1'b0;
      for (int i = 0; i < N_HOLES; i++) begin
         if (hit_sel[i]) begin
            state_d[i]  = IDLE;
            height_d[i] = '0;
         end else if (spawn_ok && (spawn_hole == HOLE_W'(i))) begin
            state_d[i]  = RISING;
            height_d[i] = HGT_W'(1);
         end else if (step) begin
            case (state_q[i])
               RISING: begin
                  height_d[i] = height_q[i] + HGT_W'(1);
                  if (height_q[i] >= MAX_SHIFT - HGT_W'(1)) begin
                     state_d[i] = UP;
                     hold_d[i]  = UP_TICKS - HOLD_W'(1);
                  end
               end
               UP: begin
                  if (hold_q[i] == '0) state_d[i] = FALLING;
                  else                 hold_d[i]  = hold_q[i] - HOLD_W'(1);
               end
               FALLING: begin
                  height_d[i] = height_q[i] - HGT_W'(1);
                  if (height_q[i] <= HGT_W'(1)) begin
                     state_d[i]  = IDLE;
                     height_d[i] = '0;
                  end
               end
               default: ;
            endcase
         end
         busy_c = busy_c | (state_d[i] != IDLE);
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         for (int i = 0; i < N_HOLES; i++) state_q[i] <= IDLE;
         height_q     <= '0;
         hold_q       <= '0;
         busy_q       <= 1'b0;
         score_q      <= '0;
         total_q      <= '0;
         spawn_cnt_q  <= SPAWN_TICKS - HOLD_W'(1);
         lfsr_q       <= LFSR_SEED;
         whack_s1_q   <= '0;
         whack_s2_q   <= '0;
         whack_prev_q <= '0;
      end else begin
         state_q      <= state_d;
         height_q     <= height_d;
         hold_q       <= hold_d;
         busy_q       <= busy_c;
         lfsr_q       <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
         whack_s1_q   <= mf.whack;
         whack_s2_q   <= whack_s1_q;
         whack_prev_q <= whack_s2_q;
         if (step) spawn_cnt_q <= spawn_go ? SPAWN_TICKS - HOLD_W'(1) : spawn_cnt_q - HOLD_W'(1);
         if (spawn_ok) total_q <= bcd_inc(total_q);
         if (|hit_sel) score_q <= bcd_inc(score_q);
      end
   end

   assign mf.mole_positions = height_q;
   assign mf.score          = score_q;
   assign mf.total          = total_q;
   assign mf.busy           = busy_q;

endmodule

// File: tb/tb_mole_field_ctrl.sv
// Directed bench for mole_field_ctrl: hole lifecycle, whack timing/priority,
// freeze, mid-game reset and BCD carry/saturation.
module tb_mole_field_ctrl;

   logic CLOCK_50 = 1'b0;
   logic resetn;
   int   checks = 0;
   int   errors = 0;

   mole_field_if mf();

   mole_field_ctrl dut (
      .CLOCK_50 (CLOCK_50),
      .resetn   (resetn),
      .mf       (mf)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   // Reference LFSR: taps 16,14,13,11, reloaded on reset, free-running otherwise.
   logic [15:0] lfsr_m;
   always @(posedge CLOCK_50) begin
      if (!resetn) lfsr_m <= 16'hACE1;
      else         lfsr_m <= {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [4:0] field(input int h);
      return mf.mole_positions[5*h +: 5];
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(negedge CLOCK_50);
   endtask

   task automatic ticks(input int n);
      mf.tick_40 = 1'b1;
      cyc(n);
      mf.tick_40 = 1'b0;
   endtask

   // Next tick is a spawn tick: idle until the LFSR points at hole h, then tick.
   task automatic spawn_on(input logic [2:0] h);
      int n = 0;
      while (lfsr_m[2:0] != h && n < 256) begin
         cyc(1);
         n++;
      end
      check_eq("spawn_align", 64'(n < 256), 64'd1);
      ticks(1);
   endtask

   // 30 ticks with an all-buttons pulse on ticks 5..9: credits the single mole
   // spawned at the end of the previous round, then spawns a new one.
   task automatic play_round();
      for (int j = 1; j <= 30; j++) begin
         mf.whack   = (j >= 5 && j <= 9) ? 8'hFF : 8'h00;
         mf.tick_40 = 1'b1;
         cyc(1);
      end
      mf.tick_40 = 1'b0;
      mf.whack   = 8'h00;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [2:0]  h0;
      logic [39:0] exp_pos;

      resetn     = 1'b0;
      mf.tick_40 = 1'b0;
      mf.game_en = 1'b0;
      mf.whack   = 8'h00;
      cyc(3);
      check_eq("rst_pos",   mf.mole_positions, 40'd0);
      check_eq("rst_score", mf.score, 16'h0000);
      check_eq("rst_total", mf.total, 16'h0000);
      check_eq("rst_busy",  mf.busy, 1'b0);

      // Lifecycle of the first spawned mole
      resetn     = 1'b1;
      mf.game_en = 1'b1;
      ticks(29);
      check_eq("pre_spawn_total", mf.total, 16'h0000);
      h0 = lfsr_m[2:0];
      ticks(1);
      exp_pos = 40'd1 << (5 * h0);
      check_eq("spawn_total", mf.total, 16'h0001);
      check_eq("spawn_pos",   mf.mole_positions, exp_pos);
      check_eq("spawn_busy",  mf.busy, 1'b1);
      ticks(18);
      check_eq("rise_top",  field(h0), 5'd19);
      ticks(40);
      check_eq("up_end",    field(h0), 5'd19);
      ticks(1);
      check_eq("fall_first", field(h0), 5'd18);
      ticks(18);
      check_eq("fall_done", field(h0), 5'd0);
      check_eq("miss_score", mf.score, 16'h0000);

      // Whack at height 10: credit on the 3rd edge, held button credits once
      resetn = 1'b0;
      cyc(2);
      resetn = 1'b1;
      ticks(29);
      spawn_on(3'd3);
      ticks(9);
      check_eq("h3_rise10", field(3), 5'd10);
      mf.whack = 8'h08;
      cyc(2);
      check_eq("hit_e2_field", field(3), 5'd10);
      check_eq("hit_e2_score", mf.score, 16'h0000);
      cyc(1);
      check_eq("hit_e3_field", field(3), 5'd0);
      check_eq("hit_e3_score", mf.score, 16'h0001);
      check_eq("hit_e3_busy",  mf.busy, 1'b0);
      cyc(197);
      ticks(20);
      spawn_on(3'd3);
      ticks(9);
      check_eq("held_field", field(3), 5'd10);
      check_eq("held_score", mf.score, 16'h0001);
      mf.whack = 8'h00;
      cyc(4);
      mf.whack = 8'h08;
      cyc(3);
      check_eq("repress_field", field(3), 5'd0);
      check_eq("repress_score", mf.score, 16'h0002);
      cyc(2);
      mf.whack = 8'h00;
      cyc(4);
      check_eq("c_total", mf.total, 16'h0002);

      // Low mole and idle hole ignore whacks; height == HIT_MIN is credited
      ticks(20);
      spawn_on(3'd6);
      ticks(2);
      check_eq("low_field", field(6), 5'd3);
      mf.whack = 8'h41;
      cyc(5);
      mf.whack = 8'h00;
      cyc(4);
      check_eq("low_keep",  field(6), 5'd3);
      check_eq("low_score", mf.score, 16'h0002);
      ticks(1);
      check_eq("min_field", field(6), 5'd4);
      mf.whack = 8'h40;
      cyc(3);
      check_eq("min_hit_field", field(6), 5'd0);
      check_eq("min_hit_score", mf.score, 16'h0003);
      cyc(2);
      mf.whack = 8'h00;
      cyc(4);

      // Two valid holes in one cycle: only the lower index is credited
      ticks(26);
      spawn_on(3'd2);
      ticks(29);
      spawn_on(3'd5);
      ticks(11);
      check_eq("pri_h2_pre", field(2), 5'd19);
      check_eq("pri_h5_pre", field(5), 5'd12);
      mf.whack = 8'h24;
      cyc(3);
      check_eq("pri_h2", field(2), 5'd0);
      check_eq("pri_h5", field(5), 5'd12);
      check_eq("pri_score", mf.score, 16'h0004);
      cyc(2);
      mf.whack = 8'h00;
      cyc(6);
      check_eq("pri_h5_late",    field(5), 5'd12);
      check_eq("pri_score_late", mf.score, 16'h0004);
      check_eq("pri_total",      mf.total, 16'h0005);

      // Freeze: ticks and whacks ignored, spawn counter held
      mf.game_en = 1'b0;
      mf.whack   = 8'h20;
      ticks(100);
      mf.whack   = 8'h00;
      cyc(4);
      check_eq("frz_pos",   mf.mole_positions, 40'd12 << 25);
      check_eq("frz_total", mf.total, 16'h0005);
      check_eq("frz_score", mf.score, 16'h0004);
      mf.game_en = 1'b1;
      ticks(18);
      check_eq("resume_h5",    field(5), 5'd19);
      check_eq("resume_total", mf.total, 16'h0005);
      spawn_on(3'd0);
      check_eq("resume_spawn", mf.total, 16'h0006);
      check_eq("resume_h0",    field(0), 5'd1);

      // Mid-rise reset with a whack in flight
      ticks(3);
      check_eq("mid_h0", field(0), 5'd4);
      mf.whack = 8'h01;
      cyc(1);
      resetn = 1'b0;
      cyc(1);
      check_eq("mid_rst_pos",   mf.mole_positions, 40'd0);
      check_eq("mid_rst_score", mf.score, 16'h0000);
      check_eq("mid_rst_total", mf.total, 16'h0000);
      check_eq("mid_rst_busy",  mf.busy, 1'b0);
      resetn = 1'b1;
      cyc(4);
      mf.whack = 8'h00;
      cyc(4);
      check_eq("post_rst_score", mf.score, 16'h0000);
      check_eq("post_rst_pos",   mf.mole_positions, 40'd0);

      // BCD carries through play: after n rounds, total = n, score = n-1
      for (int it = 1; it <= 1001; it++) begin
         play_round();
         if (it == 1) begin
            check_eq("r1_total", mf.total, 16'h0001);
            check_eq("r1_score", mf.score, 16'h0000);
         end
         if (it == 10) begin
            check_eq("r10_total", mf.total, 16'h0010);
            check_eq("r10_score", mf.score, 16'h0009);
         end
         if (it == 1000) begin
            check_eq("r1000_total", mf.total, 16'h1000);
            check_eq("r1000_score", mf.score, 16'h0999);
         end
         if (it == 1001) begin
            check_eq("r1001_total", mf.total, 16'h1001);
            check_eq("r1001_score", mf.score, 16'h1000);
         end
      end

      // Saturation at 9999
      force dut.score_q = 16'h9999;
      force dut.total_q = 16'h9999;
      #1;
      release dut.score_q;
      release dut.total_q;
      cyc(1);
      check_eq("sat_pre_score", mf.score, 16'h9999);
      play_round();
      check_eq("sat_score", mf.score, 16'h9999);
      check_eq("sat_total", mf.total, 16'h9999);
      check_eq("sat_busy",  mf.busy, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
